// File: rtl/audio_source_mixer.sv
// Per-sample FM/PSG mixer ahead of the IIR filters: snapshots inputs on each clk/div tick,
// applies gains through one shared multiplier, sums, saturates and strobes out 16-bit L/R samples.
module audio_source_mixer #(
    parameter int COUNT_BITS = 10,
    parameter int GAIN_WIDTH = 8,
    parameter int ACC_WIDTH  = 28
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [COUNT_BITS-1:0] div,
    input  logic signed [15:0]    fm_l,
    input  logic signed [15:0]    fm_r,
    input  logic [10:0]           psg,
    input  logic [GAIN_WIDTH-1:0] gain_fm,
    input  logic [GAIN_WIDTH-1:0] gain_psg,
    input  logic                  mute,
    output logic signed [15:0]    out_l,
    output logic signed [15:0]    out_r,
    output logic                  sample_stb,
    output logic                  clip_l,
    output logic                  clip_r
);

    typedef enum logic [2:0] {S_IDLE, S_MUL_L, S_MUL_R, S_MUL_P, S_SAT} state_t;

    localparam logic signed [ACC_WIDTH-1:0] C_MAX = ACC_WIDTH'(32767);
    localparam logic signed [ACC_WIDTH-1:0] C_MIN = ACC_WIDTH'(-32768);

    state_t                          r_state;
    logic [COUNT_BITS-1:0]           r_count;
    logic signed [15:0]              r_fm_l;
    logic signed [15:0]              r_fm_r;
    logic [10:0]                     r_psg;
    logic [GAIN_WIDTH-1:0]           r_gain_fm;
    logic [GAIN_WIDTH-1:0]           r_gain_psg;
    logic                            r_mute;
    logic [1:0][ACC_WIDTH-1:0]       r_acc;

    logic                            w_tick;
    logic signed [16:0]              w_mul_a;
    logic signed [GAIN_WIDTH:0]      w_mul_b;
    logic signed [GAIN_WIDTH+17:0]   w_prod;
    logic signed [ACC_WIDTH-1:0]     w_prod_ext;
    logic [1:0][15:0]                w_sat;
    logic [1:0]                      w_clip;

    // div=0 wraps to all-ones, giving a full 2^COUNT_BITS period
    assign w_tick = (r_count == (div - COUNT_BITS'(1)));

    // Single 17 x (GAIN_WIDTH+1) signed multiplier, operands steered by state
    always_comb begin
        w_mul_a = '0;
        w_mul_b = '0;
        case (r_state)
            S_MUL_L: begin
                w_mul_a = {r_fm_l[15], r_fm_l};
                w_mul_b = {1'b0, r_gain_fm};
            end
            S_MUL_R: begin
                w_mul_a = {r_fm_r[15], r_fm_r};
                w_mul_b = {1'b0, r_gain_fm};
            end
            S_MUL_P: begin
                w_mul_a = {6'b0, r_psg};
                w_mul_b = {1'b0, r_gain_psg};
            end
            default: ;
        endcase
    end

    assign w_prod     = w_mul_a * w_mul_b;
    assign w_prod_ext = ACC_WIDTH'(w_prod);

    // Floor shift back to unity scale, then clamp to the signed 16-bit range
    for (genvar gi = 0; gi < 2; gi++) begin : g_sat
        logic signed [ACC_WIDTH-1:0] w_shift;
        assign w_shift    = $signed(r_acc[gi]) >>> (GAIN_WIDTH - 1);
        assign w_clip[gi] = (w_shift > C_MAX) || (w_shift < C_MIN);
        assign w_sat[gi]  = (w_shift > C_MAX) ? 16'h7FFF :
                            (w_shift < C_MIN) ? 16'h8000 : w_shift[15:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_fm_l     <= '0;
            r_fm_r     <= '0;
            r_psg      <= '0;
            r_gain_fm  <= '0;
            r_gain_psg <= '0;
            r_mute     <= 1'b0;
            r_acc      <= '0;
            out_l      <= '0;
            out_r      <= '0;
            sample_stb <= 1'b0;
            clip_l     <= 1'b0;
            clip_r     <= 1'b0;
        end else begin
            r_count    <= w_tick ? '0 : r_count + COUNT_BITS'(1);
            sample_stb <= 1'b0;
            clip_l     <= 1'b0;
            clip_r     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_fm_l     <= fm_l;
                        r_fm_r     <= fm_r;
                        r_psg      <= psg;
                        r_gain_fm  <= gain_fm;
                        r_gain_psg <= gain_psg;
                        r_mute     <= mute;
                        r_state    <= S_MUL_L;
                    end
                end
                S_MUL_L: begin
                    r_acc[0] <= w_prod_ext;
                    r_state  <= S_MUL_R;
                end
                S_MUL_R: begin
                    r_acc[1] <= w_prod_ext;
                    r_state  <= S_MUL_P;
                end
                S_MUL_P: begin
                    r_acc[0] <= r_acc[0] + w_prod_ext;
                    r_acc[1] <= r_acc[1] + w_prod_ext;
                    r_state  <= S_SAT;
                end
                S_SAT: begin
                    r_state    <= S_IDLE;
                    sample_stb <= 1'b1;
                    if (r_mute) begin
                        out_l <= '0;
                        out_r <= '0;
                    end else begin
                        out_l  <= w_sat[0];
                        out_r  <= w_sat[1];
                        clip_l <= w_clip[0];
                        clip_r <= w_clip[1];
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_source_mixer.sv
// Bench for audio_source_mixer: directed scenarios plus randomized traffic, all compared
// against a cycle-level reference model that works from plain integer arithmetic.
module tb_audio_source_mixer;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [9:0]         div = 10'd8;
    logic signed [15:0] fm_l = '0;
    logic signed [15:0] fm_r = '0;
    logic [10:0]        psg = '0;
    logic [7:0]         gain_fm = '0;
    logic [7:0]         gain_psg = '0;
    logic               mute = 1'b0;
    logic signed [15:0] out_l;
    logic signed [15:0] out_r;
    logic               sample_stb;
    logic               clip_l;
    logic               clip_r;

    int errors = 0;
    int checks = 0;

    audio_source_mixer dut (
        .clk(clk), .reset(reset), .div(div),
        .fm_l(fm_l), .fm_r(fm_r), .psg(psg),
        .gain_fm(gain_fm), .gain_psg(gain_psg), .mute(mute),
        .out_l(out_l), .out_r(out_r), .sample_stb(sample_stb),
        .clip_l(clip_l), .clip_r(clip_r)
    );

    always #5 clk = ~clk;

    // Reference model: a tick happens every div cycles (1024 when div=0); a tick is taken
    // only if the previous accepted one is at least 5 cycles old; its result appears 4 edges later.
    int                 cyc = 0;
    int                 m_count = 0;
    int                 m_free_at = 0;
    int                 m_due = 0;
    bit                 m_pend = 0;
    bit                 m_acc = 0;
    int                 m_pl, m_pr;
    bit                 m_pcl, m_pcr;
    logic               e_stb = 1'b0;
    logic               e_cl = 1'b0;
    logic               e_cr = 1'b0;
    logic signed [15:0] e_l = '0;
    logic signed [15:0] e_r = '0;

    always @(posedge clk) begin
        bit tick;
        int sl, sr;
        cyc++;
        m_acc = 0;
        if (reset) begin
            m_count = 0; m_pend = 0; m_free_at = 0;
            e_stb = 0; e_cl = 0; e_cr = 0; e_l = '0; e_r = '0;
        end else begin
            e_stb = 0; e_cl = 0; e_cr = 0;
            if (m_pend && m_due == cyc) begin
                m_pend = 0;
                e_stb = 1; e_l = 16'(m_pl); e_r = 16'(m_pr); e_cl = m_pcl; e_cr = m_pcr;
            end
            tick = (((m_count + 1) % 1024) == int'(div));
            m_count = tick ? 0 : (m_count + 1) % 1024;
            if (tick && cyc >= m_free_at) begin
                sl = (int'(fm_l) * int'(gain_fm) + int'(psg) * int'(gain_psg)) >>> 7;
                sr = (int'(fm_r) * int'(gain_fm) + int'(psg) * int'(gain_psg)) >>> 7;
                if (mute) begin sl = 0; sr = 0; end
                m_pcl = (sl > 32767) || (sl < -32768);
                m_pcr = (sr > 32767) || (sr < -32768);
                m_pl = (sl > 32767) ? 32767 : (sl < -32768) ? -32768 : sl;
                m_pr = (sr > 32767) ? 32767 : (sr < -32768) ? -32768 : sr;
                m_pend = 1; m_due = cyc + 4; m_free_at = cyc + 5; m_acc = 1;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic wait_accept(input int limit, output bit ok);
        ok = 0;
        for (int n = 0; n < limit && !ok; n++) begin
            @(posedge clk); #1;
            ok = m_acc;
        end
    endtask

    task automatic set_in(input int l, input int r, input int p, input int gf, input int gp, input bit m);
        fm_l = 16'(l); fm_r = 16'(r); psg = 11'(p);
        gain_fm = 8'(gf); gain_psg = 8'(gp); mute = m;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({sample_stb, clip_l, clip_r, out_l, out_r} !== 35'b0) begin
            errors++;
            $display("FAIL reset_state got stb=%b cl=%b cr=%b l=%0d r=%0d exp all 0",
                     sample_stb, clip_l, clip_r, out_l, out_r);
        end
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({sample_stb, out_l, out_r} !== 33'b0) begin
            errors++;
            $display("FAIL post_reset_idle got stb=%b l=%0d r=%0d exp 0", sample_stb, out_l, out_r);
        end
    endtask

    task automatic test_unity();
        int last = -1, acc_cyc = -100, nstb = 0;
        div = 10'd8;
        set_in(1000, -1000, 0, 128, 0, 0);
        do_reset();
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            checks++;
            if ({sample_stb, clip_l, clip_r, out_l, out_r} !== {e_stb, e_cl, e_cr, e_l, e_r}) begin
                errors++;
                $display("FAIL unity_model cyc=%0d got stb=%b cl=%b cr=%b l=%0d r=%0d exp stb=%b cl=%b cr=%b l=%0d r=%0d",
                         cyc, sample_stb, clip_l, clip_r, out_l, out_r, e_stb, e_cl, e_cr, e_l, e_r);
            end
            if (m_acc) acc_cyc = cyc;
            if (sample_stb) begin
                nstb++;
                $display("txn unity cyc=%0d l=%0d r=%0d", cyc, out_l, out_r);
                checks++;
                if (out_l !== 16'sd1000 || out_r !== -16'sd1000 || clip_l || clip_r) begin
                    errors++;
                    $display("FAIL unity_value got l=%0d r=%0d cl=%b cr=%b exp 1000 -1000 0 0",
                             out_l, out_r, clip_l, clip_r);
                end
                // accept edge + 4 edges = 5th cycle after the tick cycle
                checks++;
                if (cyc - acc_cyc !== 4) begin
                    errors++;
                    $display("FAIL unity_latency got %0d exp 4 edges after accept", cyc - acc_cyc);
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last !== 8) begin
                        errors++;
                        $display("FAIL unity_period got %0d exp 8", cyc - last);
                    end
                end
                last = cyc;
            end
        end
        checks++;
        if (nstb < 4) begin
            errors++;
            $display("FAIL unity_count got %0d strobes exp >=4", nstb);
        end
    endtask

    task automatic test_saturation();
        int nstb = 0;
        div = 10'd8;
        set_in(30000, -32768, 0, 255, 0, 0);
        do_reset();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            checks++;
            if ({sample_stb, clip_l, clip_r, out_l, out_r} !== {e_stb, e_cl, e_cr, e_l, e_r}) begin
                errors++;
                $display("FAIL sat_model cyc=%0d got stb=%b cl=%b cr=%b l=%0d r=%0d exp stb=%b cl=%b cr=%b l=%0d r=%0d",
                         cyc, sample_stb, clip_l, clip_r, out_l, out_r, e_stb, e_cl, e_cr, e_l, e_r);
            end
            if (sample_stb) begin
                nstb++;
                $display("txn sat cyc=%0d l=%0d r=%0d cl=%b cr=%b", cyc, out_l, out_r, clip_l, clip_r);
                checks++;
                if (out_l !== 16'sd32767 || out_r !== -16'sd32768 || !clip_l || !clip_r) begin
                    errors++;
                    $display("FAIL sat_value got l=%0d r=%0d cl=%b cr=%b exp 32767 -32768 1 1",
                             out_l, out_r, clip_l, clip_r);
                end
            end else if (clip_l || clip_r) begin
                checks++;
                errors++;
                $display("FAIL sat_clip_pulse got cl=%b cr=%b outside strobe exp 0", clip_l, clip_r);
            end
        end
        checks++;
        if (nstb < 2) begin
            errors++;
            $display("FAIL sat_count got %0d strobes exp >=2", nstb);
        end
    endtask

    task automatic test_psg();
        bit ok;
        div = 10'd8;
        set_in(0, 0, 2047, 0, 64, 0);
        do_reset();
        wait_accept(40, ok);
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (!sample_stb || out_l !== 16'sd1023 || out_r !== 16'sd1023 || !ok) begin
            errors++;
            $display("FAIL psg_path got stb=%b l=%0d r=%0d ok=%b exp 1 1023 1023", sample_stb, out_l, out_r, ok);
        end
        set_in(-1, 0, 0, 1, 0, 0);
        do_reset();
        wait_accept(40, ok);
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (!sample_stb || out_l !== -16'sd1 || out_r !== 16'sd0 || !ok) begin
            errors++;
            $display("FAIL floor_round got stb=%b l=%0d r=%0d ok=%b exp 1 -1 0", sample_stb, out_l, out_r, ok);
        end
    endtask

    task automatic test_snapshot();
        bit ok, seen = 0;
        div = 10'd8;
        set_in(500, 0, 0, 128, 0, 0);
        do_reset();
        wait_accept(40, ok);
        fm_l = 16'sd7000;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (sample_stb) begin
                seen = 1;
                $display("txn snapshot cyc=%0d l=%0d", cyc, out_l);
                checks++;
                if (out_l !== 16'sd500) begin
                    errors++;
                    $display("FAIL snapshot_hold got l=%0d exp 500", out_l);
                end
            end
        end
        checks++;
        if (!seen || !ok) begin
            errors++;
            $display("FAIL snapshot_timeout got strobe=%b accept=%b exp 1 1", seen, ok);
        end
    endtask

    task automatic test_mute();
        int nstb = 0;
        div = 10'd8;
        set_in(30000, -20000, 2047, 255, 255, 1);
        do_reset();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (sample_stb) begin
                nstb++;
                $display("txn mute cyc=%0d l=%0d r=%0d", cyc, out_l, out_r);
                checks++;
                if ({clip_l, clip_r, out_l, out_r} !== 34'b0) begin
                    errors++;
                    $display("FAIL mute_value got l=%0d r=%0d cl=%b cr=%b exp 0 0 0 0",
                             out_l, out_r, clip_l, clip_r);
                end
            end
        end
        checks++;
        if (nstb < 2) begin
            errors++;
            $display("FAIL mute_count got %0d strobes exp >=2", nstb);
        end
        mute = 1'b0;
    endtask

    task automatic test_div3();
        int last = -1, nstb = 0;
        div = 10'd3;
        set_in(100, 200, 10, 128, 128, 0);
        do_reset();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            checks++;
            if ({sample_stb, clip_l, clip_r, out_l, out_r} !== {e_stb, e_cl, e_cr, e_l, e_r}) begin
                errors++;
                $display("FAIL div3_model cyc=%0d got stb=%b l=%0d r=%0d exp stb=%b l=%0d r=%0d",
                         cyc, sample_stb, out_l, out_r, e_stb, e_l, e_r);
            end
            if (sample_stb) begin
                nstb++;
                if (last >= 0) begin
                    checks++;
                    if (cyc - last !== 6) begin
                        errors++;
                        $display("FAIL div3_period got %0d exp 6", cyc - last);
                    end
                end
                last = cyc;
            end
        end
        checks++;
        if (nstb < 8) begin
            errors++;
            $display("FAIL div3_count got %0d strobes exp >=8", nstb);
        end
    endtask

    task automatic test_reset_mid();
        bit ok, seen = 0;
        div = 10'd8;
        set_in(1234, -4321, 0, 128, 0, 0);
        do_reset();
        wait_accept(40, ok);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({sample_stb, clip_l, clip_r, out_l, out_r} !== 35'b0) begin
                errors++;
                $display("FAIL reset_abort cyc=%0d got stb=%b l=%0d r=%0d exp 0 0 0", cyc, sample_stb, out_l, out_r);
            end
        end
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (sample_stb) begin
                seen = 1;
                $display("txn reset_mid cyc=%0d l=%0d r=%0d", cyc, out_l, out_r);
                checks++;
                if (out_l !== 16'sd1234 || out_r !== -16'sd4321) begin
                    errors++;
                    $display("FAIL reset_recover got l=%0d r=%0d exp 1234 -4321", out_l, out_r);
                end
            end
        end
        checks++;
        if (!seen || !ok) begin
            errors++;
            $display("FAIL reset_recover_timeout got strobe=%b accept=%b exp 1 1", seen, ok);
        end
    endtask

    task automatic test_random();
        for (int round = 0; round < 4; round++) begin
            div = 10'($urandom_range(1, 12));
            do_reset();
            for (int i = 0; i < 400; i++) begin
                @(negedge clk);
                checks++;
                if ({sample_stb, clip_l, clip_r, out_l, out_r} !== {e_stb, e_cl, e_cr, e_l, e_r}) begin
                    errors++;
                    $display("FAIL random_model div=%0d cyc=%0d got stb=%b cl=%b cr=%b l=%0d r=%0d exp stb=%b cl=%b cr=%b l=%0d r=%0d",
                             div, cyc, sample_stb, clip_l, clip_r, out_l, out_r, e_stb, e_cl, e_cr, e_l, e_r);
                end
                if (sample_stb)
                    $display("txn random div=%0d cyc=%0d l=%0d r=%0d cl=%b cr=%b", div, cyc, out_l, out_r, clip_l, clip_r);
                @(posedge clk); #1;
                fm_l     = 16'($urandom);
                fm_r     = 16'($urandom);
                psg      = 11'($urandom);
                gain_fm  = 8'($urandom);
                gain_psg = 8'($urandom);
                mute     = ($urandom_range(0, 7) == 0);
            end
        end
        mute = 1'b0;
    endtask

    initial begin
        test_reset();
        test_unity();
        test_saturation();
        test_psg();
        test_snapshot();
        test_mute();
        test_div3();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
